// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter
// Shares one native memory-bus slave port between two masters.
// Arbitration is round-robin. A granted transaction stays locked to its owner
// until the slave answers, the owner withdraws, or the watchdog expires. When the
// watchdog expires, the transaction completes with an error and ERR_RDATA.
//
// Ports:
//   clk, reset                 system clock, synchronous active-high reset
//   m{0,1}_valid/addr/wdata/wstrb   master requests (wstrb == 0 means read)
//   m{0,1}_ready/rdata/error        per-master completion, read data, timeout strobe
//   s_valid/addr/wdata/wstrb        request forwarded to the slave
//   s_ready/rdata                   slave completion and read data
//   grant                      one-hot current owner, 00 when no owner
//   timeout_flag, timeout_clr  sticky timeout indicator and its clear
//
// state   | meaning
// IDLE    | no owner; picks the next master from the current requests
// BUSY    | owner's request is forwarded to the slave; watchdog running
// RELEASE | single dead cycle after a transaction so a late-dropping valid is not served twice
module mem_bus_arbiter #(
    parameter int          TIMEOUT_CYCLES = 1024,
    parameter logic [31:0] ERR_RDATA      = 32'hDEADBEEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        m0_valid,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic [3:0]  m0_wstrb,
    output logic        m0_ready,
    output logic [31:0] m0_rdata,
    output logic        m0_error,
    input  logic        m1_valid,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic [3:0]  m1_wstrb,
    output logic        m1_ready,
    output logic [31:0] m1_rdata,
    output logic        m1_error,
    output logic        s_valid,
    output logic [31:0] s_addr,
    output logic [31:0] s_wdata,
    output logic [3:0]  s_wstrb,
    input  logic        s_ready,
    input  logic [31:0] s_rdata,
    output logic [1:0]  grant,
    output logic        timeout_flag,
    input  logic        timeout_clr
);

    localparam int WDOG_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BUSY    = 2'd1,
        ST_RELEASE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic              owner_q, owner_d;
    logic              last_q, last_d;
    logic [WDOG_W-1:0] wdog_q, wdog_d;
    logic              timeout_flag_q, timeout_flag_d;

    logic        own_valid;
    logic        done;
    logic        err;
    logic [31:0] done_rdata;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            owner_q        <= 1'b0;
            last_q         <= 1'b1;
            wdog_q         <= '0;
            timeout_flag_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            owner_q        <= owner_d;
            last_q         <= last_d;
            wdog_q         <= wdog_d;
            timeout_flag_q <= timeout_flag_d;
        end
    end

    assign own_valid = owner_q ? m1_valid : m0_valid;

    always_comb begin
        state_d        = state_q;
        owner_d        = owner_q;
        last_d         = last_q;
        wdog_d         = wdog_q;
        timeout_flag_d = timeout_flag_q;
        done           = 1'b0;
        err            = 1'b0;
        grant          = 2'b00;
        s_valid        = 1'b0;

        if (timeout_clr) begin
            timeout_flag_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (m0_valid || m1_valid) begin
                    // On a tie the master that was not served last wins.
                    if (m0_valid && m1_valid) begin
                        owner_d = ~last_q;
                    end else begin
                        owner_d = m1_valid;
                    end
                    state_d = ST_BUSY;
                    wdog_d  = '0;
                end
            end
            ST_BUSY: begin
                grant   = owner_q ? 2'b10 : 2'b01;
                s_valid = own_valid;
                if (!own_valid) begin
                    state_d = ST_RELEASE;
                    last_d  = owner_q;
                end else if (s_ready) begin
                    done    = 1'b1;
                    state_d = ST_RELEASE;
                    last_d  = owner_q;
                end else if (wdog_q == WDOG_LAST) begin
                    // Timeout set has priority over a simultaneous clear.
                    done           = 1'b1;
                    err            = 1'b1;
                    timeout_flag_d = 1'b1;
                    state_d        = ST_RELEASE;
                    last_d         = owner_q;
                end else begin
                    wdog_d = wdog_q + 1'b1;
                end
            end
            ST_RELEASE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign done_rdata = err ? ERR_RDATA : s_rdata;

    assign s_addr  = owner_q ? m1_addr  : m0_addr;
    assign s_wdata = owner_q ? m1_wdata : m0_wdata;
    assign s_wstrb = owner_q ? m1_wstrb : m0_wstrb;

    assign m0_ready = done && !owner_q;
    assign m1_ready = done &&  owner_q;
    assign m0_error = err  && !owner_q;
    assign m1_error = err  &&  owner_q;
    assign m0_rdata = m0_ready ? done_rdata : 32'h0;
    assign m1_rdata = m1_ready ? done_rdata : 32'h0;

    assign timeout_flag = timeout_flag_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
module tb_mem_bus_arbiter;

    localparam int          TO  = 8;
    localparam logic [31:0] ERR = 32'hDEADBEEF;

    logic        clk = 1'b0;
    logic        reset;
    logic        m0_valid, m1_valid;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic [3:0]  m0_wstrb, m1_wstrb;
    logic        m0_ready, m0_error, m1_ready, m1_error;
    logic [31:0] m0_rdata, m1_rdata;
    logic        s_valid, s_ready;
    logic [31:0] s_addr, s_wdata, s_rdata;
    logic [3:0]  s_wstrb;
    logic [1:0]  grant;
    logic        timeout_flag, timeout_clr;

    always #5 clk = ~clk;

    mem_bus_arbiter #(.TIMEOUT_CYCLES(TO), .ERR_RDATA(ERR)) dut (
        .clk(clk), .reset(reset),
        .m0_valid(m0_valid), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb),
        .m0_ready(m0_ready), .m0_rdata(m0_rdata), .m0_error(m0_error),
        .m1_valid(m1_valid), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb),
        .m1_ready(m1_ready), .m1_rdata(m1_rdata), .m1_error(m1_error),
        .s_valid(s_valid), .s_addr(s_addr), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
        .s_ready(s_ready), .s_rdata(s_rdata),
        .grant(grant), .timeout_flag(timeout_flag), .timeout_clr(timeout_clr)
    );

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    int   served[$];
    int   checks = 0;
    int   failures = 0;
    int   force_lat = -1;
    bit   force_rd_en = 1'b0;
    logic [31:0] force_rd = 32'h0;
    bit   any_to = 1'b0;
    int   g0_cyc = 0;
    int   scnt = 0;

    // Slave model: answers after a latency chosen by address (or forced), counting
    // from the first cycle it sees s_valid; read data is a fixed function of address.
    function automatic int slave_lat(input logic [31:0] a, input int fl);
        return (fl >= 0) ? fl : int'(a[3:0]);
    endfunction

    function automatic logic [31:0] slave_data(input logic [31:0] a, input bit en, input logic [31:0] rd);
        return en ? rd : ((a ^ 32'h3C5A_96F0) + 32'h11);
    endfunction

    always @(posedge clk) begin
        if (reset || !s_valid) scnt <= 0;
        else                   scnt <= scnt + 1;
    end

    assign s_ready = s_valid && (scnt == slave_lat(s_addr, force_lat));
    assign s_rdata = s_ready ? slave_data(s_addr, force_rd_en, force_rd) : 32'h0;

    always @(negedge clk) begin
        if (grant == 2'b01) g0_cyc <= g0_cyc + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic fail_now(input string name, input string what);
        checks++;
        failures++;
        $display("FAIL %s %s", name, what);
    endtask

    // Monitor: pops the scoreboard whenever a master sees a completion.
    always @(negedge clk) begin
        exp_t e;
        if (!reset) begin
            if (m0_ready) begin
                check("m0_grant", {30'h0, grant}, 32'd1);
                if (q0.size() == 0) fail_now("m0_unexpected_ready", "actual=ready required=none");
                else begin
                    e = q0.pop_front();
                    check("m0_rdata", m0_rdata, e.rdata);
                    check("m0_error", {31'h0, m0_error}, {31'h0, e.err});
                    served.push_back(0);
                end
            end else if (m0_error) fail_now("m0_error_alone", "actual=error required=none");
            if (m1_ready) begin
                check("m1_grant", {30'h0, grant}, 32'd2);
                if (q1.size() == 0) fail_now("m1_unexpected_ready", "actual=ready required=none");
                else begin
                    e = q1.pop_front();
                    check("m1_rdata", m1_rdata, e.rdata);
                    check("m1_error", {31'h0, m1_error}, {31'h0, e.err});
                    served.push_back(1);
                end
            end else if (m1_error) fail_now("m1_error_alone", "actual=error required=none");
            if (s_valid) begin
                if (grant == 2'b01) begin
                    check("s_addr_m0", s_addr, m0_addr);
                    check("s_wdata_m0", s_wdata, m0_wdata);
                    check("s_wstrb_m0", {28'h0, s_wstrb}, {28'h0, m0_wstrb});
                end else if (grant == 2'b10) begin
                    check("s_addr_m1", s_addr, m1_addr);
                    check("s_wdata_m1", s_wdata, m1_wdata);
                    check("s_wstrb_m1", {28'h0, s_wstrb}, {28'h0, m1_wstrb});
                end else fail_now("s_valid_no_grant", $sformatf("actual grant=%b required=one-hot", grant));
            end
        end
    end

    task automatic do_req(input int m, input logic [31:0] a, input logic [31:0] wd,
                          input logic [3:0] ws, input bit hold);
        exp_t e;
        int   lat;
        bit   got;
        lat     = slave_lat(a, force_lat);
        e.err   = (lat >= TO);
        e.rdata = e.err ? ERR : slave_data(a, force_rd_en, force_rd);
        if (e.err) any_to = 1'b1;
        @(posedge clk); #1;
        if (m == 0) begin
            q0.push_back(e);
            m0_valid = 1'b1; m0_addr = a; m0_wdata = wd; m0_wstrb = ws;
        end else begin
            q1.push_back(e);
            m1_valid = 1'b1; m1_addr = a; m1_wdata = wd; m1_wstrb = ws;
        end
        got = 1'b0;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clk);
            got = (m == 0) ? m0_ready : m1_ready;
        end
        if (!got) fail_now("req_no_ready", $sformatf("master=%0d actual=no ready required=ready", m));
        @(posedge clk); #1;
        if (hold) begin
            @(posedge clk); #1;
        end
        if (m == 0) m0_valid = 1'b0;
        else        m1_valid = 1'b0;
    endtask

    task automatic rand_master(input int m, input int n);
        logic [31:0] a;
        logic [31:0] wd;
        logic [3:0]  ws;
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, 3)) @(posedge clk);
            a      = $urandom();
            a[3:0] = 4'($urandom_range(0, 9));
            wd     = $urandom();
            ws     = 4'($urandom_range(0, 15));
            do_req(m, a, wd, ws, 1'($urandom_range(0, 1)));
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_time_limit actual=expired required=finish");
        $fatal(1, "time limit");
    end

    initial begin
        reset = 1'b1; timeout_clr = 1'b0;
        m0_valid = 1'b0; m0_addr = '0; m0_wdata = '0; m0_wstrb = '0;
        m1_valid = 1'b0; m1_addr = '0; m1_wdata = '0; m1_wstrb = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_grant", {30'h0, grant}, 32'h0);
        check("rst_s_valid", {31'h0, s_valid}, 32'h0);
        check("rst_readies", {30'h0, m1_ready, m0_ready}, 32'h0);
        check("rst_flag", {31'h0, timeout_flag}, 32'h0);
        @(posedge clk); #1 reset = 1'b0;

        // 1: m0 read, slave answers on the third BUSY cycle
        force_lat = 2; force_rd_en = 1'b1; force_rd = 32'h12345678;
        do_req(0, 32'h100, 32'h0, 4'h0, 1'b0);
        @(negedge clk);
        check("t1_release_grant", {30'h0, grant}, 32'h0);
        check("t1_ready_single", {31'h0, m0_ready}, 32'h0);

        // 2: m1 write
        force_lat = 1; force_rd_en = 1'b0;
        do_req(1, 32'h40000004, 32'hA5, 4'b0001, 1'b0);

        // 3: both masters requesting continuously; strict alternation from m0
        repeat (2) @(posedge clk);
        served.delete();
        fork
            for (int i = 0; i < 4; i++) do_req(0, 32'h200 + 32'(i * 16), 32'(i), 4'hF, 1'b0);
            for (int i = 0; i < 4; i++) do_req(1, 32'h300 + 32'(i * 16), 32'(i), 4'h3, 1'b0);
        join
        check("t3_count", served.size(), 32'd8);
        for (int i = 0; i < served.size(); i++) check($sformatf("t3_order_%0d", i), served[i], 32'(i % 2));

        // 4: watchdog expiry
        repeat (2) @(posedge clk);
        force_lat = 100; force_rd_en = 1'b0;
        g0_cyc = 0;
        do_req(0, 32'h500, 32'h0, 4'h0, 1'b0);
        check("t4_busy_cycles", g0_cyc, 32'd8);
        @(negedge clk);
        check("t4_flag_set", {31'h0, timeout_flag}, 32'h1);
        @(posedge clk); #1 timeout_clr = 1'b1;
        @(posedge clk); #1 timeout_clr = 1'b0;
        @(negedge clk);
        check("t4_flag_clr", {31'h0, timeout_flag}, 32'h0);

        // 5: slave answers on the last allowed cycle
        force_lat = 7;
        g0_cyc = 0;
        do_req(0, 32'h600, 32'h0, 4'h0, 1'b0);
        check("t5_busy_cycles", g0_cyc, 32'd8);
        @(negedge clk);
        check("t5_flag_clear", {31'h0, timeout_flag}, 32'h0);

        // abort: owner drops valid with no answer; no ready, bus released
        force_lat = 100;
        @(posedge clk); #1 m0_valid = 1'b1; m0_addr = 32'h700;
        repeat (3) @(negedge clk);
        @(posedge clk); #1 m0_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("abort_grant", {30'h0, grant}, 32'h0);
        check("abort_flag", {31'h0, timeout_flag}, 32'h0);

        // 6: reset in the middle of an m1 transaction
        @(posedge clk); #1 m1_valid = 1'b1; m1_addr = 32'h800;
        begin : wait_m1
            bit seen;
            seen = 1'b0;
            for (int i = 0; i < 10 && !seen; i++) begin
                @(negedge clk);
                seen = (grant == 2'b10);
            end
            if (!seen) fail_now("t6_no_grant", "actual=none required=grant 10");
        end
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("t6_s_valid", {31'h0, s_valid}, 32'h0);
        check("t6_grant", {30'h0, grant}, 32'h0);
        check("t6_m1_ready", {31'h0, m1_ready}, 32'h0);
        @(posedge clk); #1 reset = 1'b0; m1_valid = 1'b0;
        force_lat = 1;
        served.delete();
        fork
            do_req(0, 32'h900, 32'h1, 4'h1, 1'b0);
            do_req(1, 32'hA00, 32'h2, 4'h2, 1'b0);
        join
        check("t6_first_m0", (served.size() > 0) ? served[0] : -1, 32'd0);

        // Randomised traffic against the scoreboard
        force_lat = -1;
        any_to = 1'b0;
        fork
            rand_master(0, 30);
            rand_master(1, 30);
        join
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rand_q0_drained", q0.size(), 32'd0);
        check("rand_q1_drained", q1.size(), 32'd0);
        check("rand_flag", {31'h0, timeout_flag}, {31'h0, any_to});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
